// File: rtl/param_proc.sv
// Multicycle register-file processor: LOAD/MOVE in two cycles, ALU ops through
// an A/G register pair over a single shared internal bus.
module param_proc #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NREG    = 4,
   localparam int unsigned RSEL_W = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Run,
   input  logic [RSEL_W-1:0] Rx,
   input  logic [RSEL_W-1:0] Ry,
   input  logic [2:0]        Fun,
   input  logic [WIDTH-1:0]  Data,
   output logic              Done,
   output logic              Busy,
   output logic              Err,
   output logic [WIDTH-1:0]  BusWires,
   output logic              Cflag,
   output logic              Zflag
);

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_MOVE = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_e;

   typedef struct packed {
      logic [2:0]        fun;
      logic [RSEL_W-1:0] rx;
      logic [RSEL_W-1:0] ry;
      logic [WIDTH-1:0]  data;
   } instr_t;

   state_e             state_q, state_d;
   instr_t             ir_q;
   logic [WIDTH-1:0]   regs_q [NREG];
   logic [WIDTH-1:0]   a_q, g_q;
   logic               c_q, z_q;

   logic [WIDTH-1:0]   bus_c;
   logic               ir_ld_c, a_ld_c, g_ld_c, wr_en_c;
   logic [WIDTH-1:0]   alu_res_c;
   logic               alu_cy_c;
   logic [WIDTH:0]     sum_c, diff_c;

   // Next-state, bus select and datapath strobes
   always_comb begin
      state_d = state_q;
      bus_c   = '0;
      ir_ld_c = 1'b0;
      a_ld_c  = 1'b0;
      g_ld_c  = 1'b0;
      wr_en_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (Run) begin
               ir_ld_c = 1'b1;
               state_d = S1;
            end
         end
         S1: begin
            state_d = DONE;
            case (ir_q.fun)
               OP_LOAD: begin
                  bus_c   = ir_q.data;
                  wr_en_c = 1'b1;
               end
               OP_MOVE: begin
                  bus_c   = regs_q[ir_q.ry];
                  wr_en_c = 1'b1;
               end
               OP_RSVD: bus_c = '0;
               default: begin
                  bus_c   = regs_q[ir_q.rx];
                  a_ld_c  = 1'b1;
                  state_d = S2;
               end
            endcase
         end
         S2: begin
            bus_c   = regs_q[ir_q.ry];
            g_ld_c  = 1'b1;
            state_d = S3;
         end
         S3: begin
            bus_c   = g_q;
            wr_en_c = 1'b1;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ALU: A against the bus; SUB carry means "no borrow"
   always_comb begin
      sum_c     = {1'b0, a_q} + {1'b0, bus_c};
      diff_c    = {1'b0, a_q} - {1'b0, bus_c};
      alu_res_c = '0;
      alu_cy_c  = 1'b0;
      case (ir_q.fun)
         OP_ADD: begin
            alu_res_c = sum_c[WIDTH-1:0];
            alu_cy_c  = sum_c[WIDTH];
         end
         OP_SUB: begin
            alu_res_c = diff_c[WIDTH-1:0];
            alu_cy_c  = ~diff_c[WIDTH];
         end
         OP_AND:  alu_res_c = a_q & bus_c;
         OP_OR:   alu_res_c = a_q | bus_c;
         OP_XOR:  alu_res_c = a_q ^ bus_c;
         default: alu_res_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ir_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (ir_ld_c) ir_q <= '{fun: Fun, rx: Rx, ry: Ry, data: Data};
         if (a_ld_c)  a_q  <= bus_c;
         if (g_ld_c) begin
            g_q <= alu_res_c;
            c_q <= alu_cy_c;
            z_q <= (alu_res_c == '0);
         end
      end
   end

   // Register file: single write port fed from the bus
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wr_en_c) begin
         regs_q[ir_q.rx] <= bus_c;
      end
   end

   assign Done     = (state_q == DONE);
   assign Err      = (state_q == DONE) && (ir_q.fun == OP_RSVD);
   assign Busy     = (state_q != IDLE);
   assign BusWires = bus_c;
   assign Cflag    = c_q;
   assign Zflag    = z_q;

endmodule

// File: tb/tb_param_proc.sv
// Randomized self-checking bench for param_proc against an instruction-level model.
module tb_param_proc;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned NREG  = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       Run;
   logic [1:0] Rx, Ry;
   logic [2:0] Fun;
   logic [7:0] Data;
   logic       Done, Busy, Err;
   logic [7:0] BusWires;
   logic       Cflag, Zflag;

   int n_tests = 0;
   int n_fail  = 0;

   int mreg [NREG];
   bit mc, mz;

   param_proc #(.WIDTH(WIDTH), .NREG(NREG)) dut (
      .clk(clk), .reset(reset), .Run(Run), .Rx(Rx), .Ry(Ry), .Fun(Fun), .Data(Data),
      .Done(Done), .Busy(Busy), .Err(Err), .BusWires(BusWires), .Cflag(Cflag), .Zflag(Zflag)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Instruction-level result: returns result, carry, whether it writes and is ALU
   function automatic void model_op(input logic [2:0] f, input int a, input int b, input int d,
                                    output int g, output bit c, output bit we, output bit alu);
      g = 0; c = 1'b0; we = 1'b0; alu = 1'b0;
      case (f)
         3'd0: begin g = d; we = 1'b1; end
         3'd1: begin g = b; we = 1'b1; end
         3'd2: begin g = a + b; c = (g > 255); g = g % 256; we = 1'b1; alu = 1'b1; end
         3'd3: begin c = (a >= b); g = (a - b + 256) % 256; we = 1'b1; alu = 1'b1; end
         3'd4: begin g = a & b; we = 1'b1; alu = 1'b1; end
         3'd5: begin g = a | b; we = 1'b1; alu = 1'b1; end
         3'd6: begin g = a ^ b; we = 1'b1; alu = 1'b1; end
         default: ;
      endcase
   endfunction

   // Issue one instruction and check latency, bus per cycle, Err, idle state and flags
   task automatic exec(input logic [2:0] f, input int rx, input int ry, input logic [7:0] d);
      int a, b, g, lat, done_k;
      bit c, we, alu, e_err;
      logic [7:0] exp_bus [1:3];
      logic [7:0] bs [1:8];
      a = mreg[rx];
      b = mreg[ry];
      model_op(f, a, b, int'(d), g, c, we, alu);
      lat = alu ? 4 : 2;
      exp_bus[1] = (f == 3'd0) ? d : (f == 3'd1) ? 8'(b) : (f == 3'd7) ? 8'h00 : 8'(a);
      exp_bus[2] = 8'(b);
      exp_bus[3] = 8'(g);
      @(negedge clk);
      Run = 1'b1; Fun = f; Rx = 2'(rx); Ry = 2'(ry); Data = d;
      @(posedge clk); #1;
      Run = 1'b0; Fun = 3'($urandom); Rx = 2'($urandom); Ry = 2'($urandom); Data = 8'($urandom);
      done_k = 0; e_err = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         bs[k] = BusWires;
         n_tests++;
         if (Busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_active f=%0d k=%0d got %b want 1", f, k, Busy);
         end
         if (Done === 1'b1) begin done_k = k; e_err = Err; break; end
      end
      n_tests++;
      if (done_k !== lat) begin
         n_fail++; $display("FAIL latency f=%0d got %0d want %0d", f, done_k, lat);
      end
      for (int k = 1; k < lat; k++) begin
         n_tests++;
         if (bs[k] !== exp_bus[k]) begin
            n_fail++; $display("FAIL bus f=%0d rx=%0d ry=%0d cycle %0d got %h want %h", f, rx, ry, k, bs[k], exp_bus[k]);
         end
      end
      n_tests++;
      if (e_err !== (f == 3'd7)) begin
         n_fail++; $display("FAIL err f=%0d got %b want %b", f, e_err, (f == 3'd7));
      end
      if (done_k != 0) begin
         n_tests++;
         if (bs[done_k] !== 8'h00) begin
            n_fail++; $display("FAIL bus_in_done got %h want 00", bs[done_k]);
         end
      end
      if (we) mreg[rx] = g;
      if (alu) begin mc = c; mz = (g == 0); end
      @(posedge clk); #1;
      n_tests++;
      if (Busy !== 1'b0 || Done !== 1'b0 || BusWires !== 8'h00) begin
         n_fail++; $display("FAIL idle_after got busy=%b done=%b bus=%h want 0 0 00", Busy, Done, BusWires);
      end
      n_tests++;
      if ({Cflag, Zflag} !== {mc, mz}) begin
         n_fail++; $display("FAIL flags f=%0d got C=%b Z=%b want C=%b Z=%b", f, Cflag, Zflag, mc, mz);
      end
   endtask

   // Observe every register through a self-MOVE
   task automatic check_regs();
      for (int k = 0; k < NREG; k++) exec(3'd1, k, k, 8'($urandom));
   endtask

   task automatic test_reset();
      reset = 1'b0; Run = 1'b0; Fun = '0; Rx = '0; Ry = '0; Data = '0;
      for (int i = 0; i < NREG; i++) mreg[i] = 0;
      mc = 1'b0; mz = 1'b0;
      #12;
      n_tests++;
      if ({Done, Busy, Err, BusWires, Cflag, Zflag} !== 13'h0) begin
         n_fail++; $display("FAIL reset_outputs got %b want 0", {Done, Busy, Err, BusWires, Cflag, Zflag});
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_idle got busy=%b done=%b want 0 0", Busy, Done);
      end
      check_regs();
   endtask

   task automatic test_load_move();
      exec(3'd0, 2, $urandom_range(0, 3), 8'h5A);
      exec(3'd1, 0, 2, 8'($urandom));
      check_regs();
   endtask

   task automatic test_add_sub();
      exec(3'd0, 1, 0, 8'hF0);
      exec(3'd0, 3, 0, 8'h20);
      exec(3'd2, 1, 3, 8'($urandom));
      exec(3'd3, 1, 1, 8'($urandom));
      exec(3'd0, 0, 0, 8'h05);
      exec(3'd0, 2, 0, 8'h07);
      exec(3'd3, 0, 2, 8'($urandom));
      check_regs();
   endtask

   task automatic test_reserved();
      exec(3'd0, 3, 0, 8'hC3);
      exec(3'd2, 3, 3, 8'($urandom));
      exec(3'd7, 0, $urandom_range(0, 3), 8'($urandom));
      check_regs();
   endtask

   task automatic test_back_to_back();
      int d1, ry2, a, b, g;
      bit c, we, alu;
      logic busy_s [1:10];
      logic done_s [1:10];
      logic [7:0] bus_s [1:10];
      d1 = $urandom_range(0, 255);
      ry2 = $urandom_range(0, 3);
      @(negedge clk);
      Run = 1'b1; Fun = 3'd0; Rx = 2'd3; Ry = 2'($urandom); Data = 8'(d1);
      @(posedge clk); #1;
      Fun = 3'd2; Rx = 2'd3; Ry = 2'(ry2); Data = 8'($urandom);
      mreg[3] = d1;
      a = mreg[3]; b = mreg[ry2];
      model_op(3'd2, a, b, 0, g, c, we, alu);
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) begin @(posedge clk); #1; end
         busy_s[k] = Busy; done_s[k] = Done; bus_s[k] = BusWires;
         if (k == 4) Run = 1'b0;
      end
      for (int k = 1; k <= 10; k++) begin
         n_tests++;
         if (busy_s[k] !== ((k <= 7) && (k != 3)) || done_s[k] !== ((k == 2) || (k == 7))) begin
            n_fail++; $display("FAIL b2b_handshake cycle %0d got busy=%b done=%b want busy=%b done=%b",
                               k, busy_s[k], done_s[k], (k <= 7) && (k != 3), (k == 2) || (k == 7));
         end
      end
      n_tests++;
      if (bus_s[4] !== 8'(a) || bus_s[5] !== 8'(b) || bus_s[6] !== 8'(g)) begin
         n_fail++; $display("FAIL b2b_bus got %h %h %h want %h %h %h", bus_s[4], bus_s[5], bus_s[6], 8'(a), 8'(b), 8'(g));
      end
      mreg[3] = g; mc = c; mz = (g == 0);
      n_tests++;
      if ({Cflag, Zflag} !== {mc, mz}) begin
         n_fail++; $display("FAIL b2b_flags got C=%b Z=%b want C=%b Z=%b", Cflag, Zflag, mc, mz);
      end
      check_regs();
   endtask

   task automatic test_reset_mid_op();
      exec(3'd0, 1, 0, 8'hFF);
      exec(3'd0, 2, 0, 8'h01);
      exec(3'd2, 0, 0, 8'h00);
      @(negedge clk);
      Run = 1'b1; Fun = 3'd2; Rx = 2'd1; Ry = 2'd2; Data = 8'($urandom);
      @(posedge clk); #1;
      Run = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (Busy !== 1'b1 || BusWires !== 8'h01) begin
         n_fail++; $display("FAIL s2_before_reset got busy=%b bus=%h want 1 01", Busy, BusWires);
      end
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if ({Done, Busy, Err, BusWires, Cflag, Zflag} !== 13'h0) begin
         n_fail++; $display("FAIL async_reset_outputs got %b want 0", {Done, Busy, Err, BusWires, Cflag, Zflag});
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         n_tests++;
         if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL in_reset cycle %0d got done=%b busy=%b want 0 0", k, Done, Busy);
         end
      end
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < NREG; i++) mreg[i] = 0;
      mc = 1'b0; mz = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (Busy !== 1'b0 || Done !== 1'b0) begin
         n_fail++; $display("FAIL after_reset got busy=%b done=%b want 0 0", Busy, Done);
      end
      check_regs();
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++)
         exec(3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
      check_regs();
   endtask

   initial begin
      test_reset();
      test_load_move();
      test_add_sub();
      test_reserved();
      test_back_to_back();
      test_reset_mid_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/param_proc.md
PARAM_PROC -- requirements
Module: param_proc

Interface
REQ-001 Parameter WIDTH, default 8, data path and register width in bits (>=4).
REQ-002 Parameter NREG, default 4, number of general registers (power of two, >=2); derived RSEL_W = clog2(NREG).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Run  input  1  instruction start request, sampled only in IDLE.
REQ-006 Rx  input  RSEL_W  destination / first-operand register select.
REQ-007 Ry  input  RSEL_W  second-operand / move-source register select.
REQ-008 Fun  input  3  operation code (see REQ-013).
REQ-009 Data  input  WIDTH  immediate value for LOAD.
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 Err  output  1  high together with Done when the completed opcode was reserved; otherwise low.
REQ-012a BusWires  output  WIDTH  internal bus value, observation only (no tristate; internal mux).
REQ-012b Cflag, Zflag  output  1 each  carry and zero flags of the last ALU operation.

Function
REQ-013 Fun decode: 000 LOAD Rx<-Data; 001 MOVE Rx<-Ry; 010 ADD; 011 SUB (Rx-Ry); 100 AND; 101 OR; 110 XOR; 111 reserved.
REQ-014 In IDLE, Run=1 at a rising edge SHALL latch Fun, Rx, Ry and Data into an instruction register and enter S1; later input changes have no effect on the current instruction.
REQ-015 States: IDLE, S1, S2, S3, DONE; Run SHALL be ignored in every state but IDLE.
REQ-016 LOAD/MOVE: S1 drives latched Data / R[Ry] on the bus; next edge writes R[Rx] and enters DONE.
REQ-017 ALU ops: S1 bus=R[Rx], edge loads A -> S2; S2 bus=R[Ry], edge loads G=A op bus and the flags -> S3; S3 bus=G, edge writes R[Rx]=G -> DONE.
REQ-018 Reserved: S1 drives bus 0, writes nothing -> DONE with Err=1.
REQ-019 DONE lasts exactly one cycle with Done=1, then IDLE; Done=0 in all other states.
REQ-020 Latency from accepting edge to Done high: 2 cycles for LOAD/MOVE/reserved, 4 cycles for ALU ops.
REQ-021 ADD: G=(A+B) mod 2^WIDTH, Cflag = carry out of bit WIDTH-1.
REQ-022 SUB: G=(A-B) mod 2^WIDTH, Cflag=1 when A>=B (no borrow), else 0.
REQ-023 AND/OR/XOR: bitwise, Cflag=0.
REQ-024 Zflag=1 iff G==0; flags update only at the S2 edge of ALU ops; LOAD/MOVE/reserved leave them unchanged.
REQ-025 Rx==Ry is legal for all opcodes; it reads the pre-instruction value of the register.
REQ-026 BusWires SHALL be 0 in IDLE and DONE.
REQ-027 Only one register is written per instruction; the write occurs only on the edge leaving S1 (LOAD/MOVE) or S3 (ALU).

Reset
REQ-028 reset low SHALL immediately force state IDLE and clear all registers R[0..NREG-1], A, G, the instruction register, Cflag and Zflag to 0, independent of clk.
REQ-029 While reset is low: Done=0, Busy=0, Err=0, BusWires=0; an instruction in progress is abandoned with no Done pulse.
REQ-030 After reset releases, the first Run=1 edge in IDLE SHALL be accepted normally.

Verification (WIDTH=8, NREG=4)
REQ-031 LOAD R2<-0x5A, then MOVE R0<-R2 -> Done 2 cycles after each accept; R0=R2=0x5A; flags unchanged (0).
REQ-032 LOAD R1=0xF0, R3=0x20; ADD Rx=1, Ry=3 -> Done 4 cycles after accept; R1=0x10, Cflag=1, Zflag=0; R3 unchanged.
REQ-033 SUB Rx=Ry=1 with R1=0x10 -> R1=0x00, Cflag=1, Zflag=1; SUB 0x05-0x07 -> 0xFE, Cflag=0, Zflag=0.
REQ-034 Run held high across a LOAD then an ADD -> second instruction is accepted only on the edge after DONE; Busy stays low for exactly one cycle between them.
REQ-035 reset pulsed low while in S2 of an ADD -> all registers and flags 0, no Done pulse, Busy=0 until next accepted Run.
REQ-036 Fun=111 with Rx=0 -> Done and Err high in the same single cycle 2 cycles after accept; all registers and flags unchanged.
